// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory req/ack bus between fetch unit and memory
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage feeding IF/ID through a small fetch queue
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nop_lock_id,
    input  logic                  pc_bj,
    input  logic [31:0]           pc_bj_target,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           instruction_if,
    output logic [31:0]           pc_if
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state_q;
    logic            req_q;
    logic [31:0]     addr_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            empty;
    logic            ack;
    logic            enq;
    logic            pop;
    logic            room;
    logic [31:0]     target;
    logic [31:0]     pc_plus4;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // an ack only counts while a request is actually on the bus
    assign ack      = imem.imem_ack && req_q;
    assign empty    = (count_q == '0);
    assign enq      = (state_q == REQ) && ack && !pc_bj;
    assign pop      = !empty && !nop_lock_id && !pc_bj;
    assign count_d  = count_q + CW'(enq) - CW'(pop);
    assign room     = (count_d < CW'(DEPTH));
    assign target   = {pc_bj_target[31:2], 2'b00};
    assign pc_plus4 = fetch_pc_q + 32'd4;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign instruction_if = (!empty && !pc_bj) ? instr_mem_q[head_q] : NOP_INSTR;
    assign pc_if          = (!empty && !pc_bj) ? pc_mem_q[head_q]    : fetch_pc_q;

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[tail_q] <= imem.imem_rdata;
            pc_mem_q[tail_q]    <= addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            if (pc_bj) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) tail_q <= ptr_inc(tail_q);
                if (pop) head_q <= ptr_inc(head_q);
                count_q <= count_d;
            end

            case (state_q)
                IDLE: begin
                    if (pc_bj) begin
                        fetch_pc_q <= target;
                    end else if (room) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (pc_bj) begin
                        fetch_pc_q <= target;
                        if (ack) addr_q  <= target;
                        else     state_q <= DROP;
                    end else if (ack) begin
                        fetch_pc_q <= pc_plus4;
                        if (room) begin
                            addr_q <= pc_plus4;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    // wrong-path request must complete before the redirect fetch goes out
                    if (pc_bj) fetch_pc_q <= target;
                    if (ack) begin
                        state_q <= REQ;
                        addr_q  <= pc_bj ? target : fetch_pc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule
